// File: rtl/edge_pulse_pkg.sv
// ---------------------------------------------------------------------------
// edge_pulse_pkg
// Shared definitions for the edge/pulse detector:
//   DEFAULT_W   - default number of channels
//   hist_t      - per-channel two-sample history {p1, p2}
//   hist_shift  - advances a history by one new sample
// ---------------------------------------------------------------------------
package edge_pulse_pkg;

    localparam int DEFAULT_W = 1;

    // p1 = sample taken last cycle, p2 = sample taken two cycles ago
    typedef struct packed {
        logic p1;
        logic p2;
    } hist_t;

    function automatic hist_t hist_shift(input hist_t h, input logic sample);
        hist_t r;
        r.p1 = sample;
        r.p2 = h.p1;
        return r;
    endfunction

endpackage : edge_pulse_pkg

// File: rtl/edge_pulse_channel.sv
// ---------------------------------------------------------------------------
// edge_pulse_channel
// One channel of the edge/pulse detector. Keeps a two-sample history of the
// level input and flags a rising edge (0->1) and an isolated one-cycle high
// pulse (0,1,0). With REG_OUT != 0 both flags pass through an output register.
//
// Ports:
//   clk              - rising-edge clock
//   rst              - synchronous active-high reset
//   a                - level input sample for this channel
//   posedge_detected - a is 1 now and was 0 last cycle
//   pulse_detected   - a is 0 now, was 1 last cycle, 0 the cycle before
// ---------------------------------------------------------------------------
module edge_pulse_channel
    import edge_pulse_pkg::*;
#(
    parameter int REG_OUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic posedge_detected,
    output logic pulse_detected
);

    hist_t hist_q;
    hist_t hist_d;
    logic  pos_c;
    logic  pul_c;

    always_comb begin
        hist_d = hist_shift(hist_q, a);
        // Flags are suppressed during reset so an event straddling the reset
        // is never reported.
        pos_c  = ~rst & a & ~hist_q.p1;
        pul_c  = ~rst & ~a & hist_q.p1 & ~hist_q.p2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic pos_q;
        logic pul_q;
        logic pos_d;
        logic pul_d;

        always_comb begin
            pos_d = pos_c;
            pul_d = pul_c;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pos_q <= 1'b0;
                pul_q <= 1'b0;
            end else begin
                pos_q <= pos_d;
                pul_q <= pul_d;
            end
        end

        assign posedge_detected = pos_q;
        assign pulse_detected   = pul_q;
    end else begin : g_comb_out
        assign posedge_detected = pos_c;
        assign pulse_detected   = pul_c;
    end

endmodule : edge_pulse_channel

// File: rtl/edge_pulse_detector.sv
// ---------------------------------------------------------------------------
// edge_pulse_detector
// W independent edge/pulse detector channels. This level only replicates the
// channel and slices the buses; all behaviour lives in edge_pulse_channel.
//
// Parameters:
//   W       - number of channels
//   REG_OUT - 0: flags combinational from the current sample
//             1: flags registered (one extra cycle of latency)
// Ports:
//   clk              - rising-edge clock
//   rst              - synchronous active-high reset
//   a[W-1:0]         - level inputs, synchronous to clk
//   posedge_detected - per-channel rising-edge flag
//   pulse_detected   - per-channel isolated one-cycle-pulse flag
// ---------------------------------------------------------------------------
module edge_pulse_detector
    import edge_pulse_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int REG_OUT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    output logic [W-1:0] posedge_detected,
    output logic [W-1:0] pulse_detected
);

    for (genvar i = 0; i < W; i++) begin : g_ch
        edge_pulse_channel #(
            .REG_OUT(REG_OUT)
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .a               (a[i]),
            .posedge_detected(posedge_detected[i]),
            .pulse_detected  (pulse_detected[i])
        );
    end

endmodule : edge_pulse_detector

// File: tb/tb_edge_pulse_detector.sv
// ---------------------------------------------------------------------------
// tb_edge_pulse_detector
// Two W=4 detectors (combinational and registered outputs) share one input.
// The driver pushes the expected response of each cycle into exp_q; a monitor
// on the falling edge pops it and compares both detectors' outputs.
// ---------------------------------------------------------------------------
module tb_edge_pulse_detector;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] pos_c;
        logic [W-1:0] pul_c;
        logic [W-1:0] pos_r;
        logic [W-1:0] pul_r;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a   = '0;

    logic [W-1:0] pos_comb;
    logic [W-1:0] pul_comb;
    logic [W-1:0] pos_reg;
    logic [W-1:0] pul_reg;

    int errors = 0;
    int checks = 0;

    exp_t         exp_q[$];
    logic [W-1:0] seen_q[$];   // samples taken since the last reset
    logic [W-1:0] prev_pos = '0;
    logic [W-1:0] prev_pul = '0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    edge_pulse_detector #(.W(W), .REG_OUT(0)) u_dut_comb (
        .clk             (clk),
        .rst             (rst),
        .a               (a),
        .posedge_detected(pos_comb),
        .pulse_detected  (pul_comb)
    );

    edge_pulse_detector #(.W(W), .REG_OUT(1)) u_dut_reg (
        .clk             (clk),
        .rst             (rst),
        .a               (a),
        .posedge_detected(pos_reg),
        .pulse_detected  (pul_reg)
    );

    // ---------------- reference model ----------------
    // Sample k cycles back within the current post-reset history (0 if absent).
    function automatic logic [W-1:0] back(input int k);
        if (seen_q.size() >= k) return seen_q[seen_q.size() - k];
        return '0;
    endfunction

    // Drive one cycle (called #1 after a rising edge) and queue its expectation.
    task automatic step(input logic [W-1:0] a_val, input logic rst_val);
        exp_t         e;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        a   = a_val;
        rst = rst_val;
        s1  = back(1);
        s2  = back(2);
        e.pos_c = '0;
        e.pul_c = '0;
        if (!rst_val) begin
            for (int i = 0; i < W; i++) begin
                e.pos_c[i] = (a_val[i] == 1'b1) && (s1[i] == 1'b0);
                e.pul_c[i] = ({s2[i], s1[i], a_val[i]} == 3'b010);
            end
        end
        // Registered outputs show last cycle's combinational result.
        e.pos_r = prev_pos;
        e.pul_r = prev_pul;
        exp_q.push_back(e);
        prev_pos = e.pos_c;
        prev_pul = e.pul_c;
        if (rst_val) seen_q.delete();
        else         seen_q.push_back(a_val);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic [W-1:0] a_val);
        for (int i = 0; i < n; i++) step(a_val, 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("comb_posedge", pos_comb, e.pos_c);
            cmp("comb_pulse",   pul_comb, e.pul_c);
            cmp("reg_posedge",  pos_reg,  e.pos_r);
            cmp("reg_pulse",    pul_reg,  e.pul_r);
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [15:0] BASE_VEC = 16'b1000_1110_0100_0100; // LSB first

    initial begin
        logic [15:0] base;
        logic [W-1:0] v;
        base = BASE_VEC;
        rst  = 1'b1;
        a    = '0;
        @(posedge clk);
        #1;

        // Base vector on bit 0
        do_reset(2, '0);
        for (int i = 0; i < 16; i++) step({3'b000, base[i]}, 1'b0);

        // a held high through reset
        do_reset(2, '1);
        step('1, 1'b0);
        step('1, 1'b0);
        step('1, 1'b0);

        // Mid-run reset swallowing a pulse
        do_reset(1, '0);
        step('0, 1'b0);
        step('1, 1'b0);
        step('0, 1'b1);
        step('0, 1'b0);
        step('0, 1'b0);

        // Alternating input
        do_reset(1, '0);
        for (int i = 0; i < 8; i++) step((i % 2 == 1) ? '1 : '0, 1'b0);

        // Channel independence: bit0 pulse, bit1 high, bit2 rise with bit0, bit3 low
        do_reset(1, 4'b0010);
        step(4'b0010, 1'b0);
        step(4'b0111, 1'b0);
        step(4'b0110, 1'b0);
        step(4'b0110, 1'b0);
        step(4'b0110, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            v = W'($urandom_range(0, (1 << W) - 1));
            step(v, ($urandom_range(0, 24) == 0));
        end
        step('0, 1'b0);

        // Let the monitor drain the last expectation, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_edge_pulse_detector

// File: doc/edge_pulse_detector.md
Name: edge_pulse_detector

Overview:
- Per-bit detector for 1-bit serial level signals, sampled once per clk cycle.
- For each channel, flags two events:
  - a rising edge (0→1);
  - an isolated one-cycle high pulse (0,1,0 over three consecutive samples).
- Sits between input synchronisers and event-counting or interrupt logic. Channels are fully independent.

Parameters:
- W, 1, number of independent input channels.
- REG_OUT, 0, 0 = detection outputs combinational from current sample (zero latency); 1 = outputs registered (one extra cycle latency).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- a  input  W  sampled level inputs, one bit per channel; must be synchronous to clk.
- posedge_detected  output  W  bit i high in the cycle a[i] is 1 and the previous sample was 0.
- pulse_detected  output  W  bit i high in the cycle a[i] is 0, previous sample 1, sample before that 0.

Behaviour:
- Per channel state: p1 = a sampled last cycle, p2 = a sampled two cycles ago. On posedge clk: p2 <= p1; p1 <= a.
- rst high at posedge clk: p1 and p2 <= 0; with REG_OUT=1 the output registers also <= 0.
- REG_OUT=0, combinational:
  - posedge_detected[i] = a[i] & ~p1[i].
  - pulse_detected[i] = ~a[i] & p1[i] & ~p2[i].
  - Both are forced to 0 while rst is high.
- REG_OUT=1: the same expressions are registered, so each output rises one cycle after the combinational case and lasts exactly one cycle.
- Output width and spacing:
  - Each detection is exactly one cycle wide per event.
  - Pulse detection fires only on the cycle the input returns low, i.e. one cycle after the pulse started.
  - High runs of 2 or more cycles never assert pulse_detected. They do assert posedge_detected on their first cycle.
- Reset history: after reset release the history is all zeros.
  - A 1 on the first sample after reset counts as a rising edge.
  - A 1,0 sequence immediately after reset counts as a one-cycle pulse.
- Reset mid-operation: history is cleared. An event straddling the reset is not reported; a rise spanning reset re-reports as a posedge on the first post-reset cycle with a=1.
- Alternating input 0,1,0,1,0…: posedge every cycle a=1; pulse every cycle a=0 after the first 0,1,0 window. Both outputs toggle out of phase.
- Simultaneous events on different channels are reported independently in the same cycle.
- Input X/Z is not handled. The bench drives known values from reset release onward.

Decomposition:
- Package edge_pulse_pkg:
  - constant DEFAULT_W = 1;
  - typedef of the per-channel 2-bit history struct {p1, p2}.
- Sub-module edge_pulse_channel:
  - one instance per bit via generate loop;
  - holds p1/p2, both detection expressions and the optional output register;
  - REG_OUT is passed down.
- Top edge_pulse_detector handles only replication and port slicing.

Test Plan:
- Base vector, W=1, REG_OUT=0. Reset for 2 cycles, then drive a LSB-first 0,0,1,0,0,0,1,0,0,1,1,1,0,0,0,1:
  - posedge_detected = 0,0,1,0,0,0,1,0,0,1,0,0,0,0,0,1;
  - pulse_detected = 0,0,0,1,0,0,0,1,0,0,0,0,0,0,0,0.
- Same sequence with REG_OUT=1 → both expected streams shifted one cycle later; first output cycle 0.
- Reset behaviour:
  - hold a=1 during reset → both outputs 0 while rst=1;
  - first cycle after release → posedge_detected=1;
  - next cycle, still a=1 → 0.
- Mid-run reset: drive a=0,1, assert rst for one cycle while a=0, release with a=0 → pulse_detected stays 0 throughout.
- Alternating 0,1,0,1,0,1 → posedge on every a=1 cycle; pulse on every a=0 cycle from the 3rd sample onward.
- Channel independence, W=4: a[0] single pulse, a[1] held high, a[2] rising at the same cycle as a[0], a[3] constant 0.
  - Check a[0] and a[2] posedge in the same cycle.
  - Check a[0] pulse only on its own bit.
  - Check no events on bit 3.
